id_lexer: RTL and testbench

//  Streaming identifier recogniser, generalised from the single-output id FSM.
//  - Accepts one character per valid cycle.
//  - Tracks runs of the form letter+ digit+ (e.g. "abcd1234"), reports the live match flag and the run length.
//  - Emits a token pulse with the token length when a matched run terminates, and keeps a running token count.
//  - Sits between a character source (UART/ROM stream) and downstream token consumers.

---
 rtl/id_lexer.sv | 171 +++++++++++++++++
 tb/tb_id_lexer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_lexer.sv
// ============================================================================
//  Module  : id_lexer
//  Brief   : Streaming letter+digit+ identifier recogniser with token pulse,
//            token length and wrapping token counter.
//            Optional macro LEXER_UNDERSCORE_EN makes '_' a letter.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_lexer #(
  parameter int CHAR_W  = 8,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] char,
  input  logic              clear,
  output logic              match,
  output logic [LEN_W-1:0]  cur_len,
  output logic              too_long,
  output logic              tok_valid,
  output logic [LEN_W-1:0]  tok_len,
  output logic [CNT_W-1:0]  tok_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALPHA = 2'd1;
  localparam logic [1:0] S_DIGIT = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] C_ONE     = LEN_W'(1);

  logic [1:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic             r_too_long;
  logic             r_tok_valid;
  logic [LEN_W-1:0] r_tok_len;
  logic [CNT_W-1:0] r_tok_cnt;

  logic [7:0]       w_lo;
  logic             w_hi_ok;
  logic             w_us;
  logic             w_is_l;
  logic             w_is_d;
  logic             w_at_max;
  logic [1:0]       w_state_nx;
  logic [LEN_W-1:0] w_len_nx;
  logic             w_too_long_nx;
  logic             w_tok;

  assign w_lo = char[7:0];

  // Any bit above the ASCII byte disqualifies the character from L and D.
  generate
    if (CHAR_W > 8) begin : g_wide
      assign w_hi_ok = ~|char[CHAR_W-1:8];
    end else begin : g_narrow
      assign w_hi_ok = 1'b1;
    end
  endgenerate

`ifdef LEXER_UNDERSCORE_EN
  assign w_us = (w_lo == 8'h5F);
`else
  assign w_us = 1'b0;
`endif

  assign w_is_l = w_hi_ok && (((w_lo >= 8'h61) && (w_lo <= 8'h7A)) ||
                              ((w_lo >= 8'h41) && (w_lo <= 8'h5A)) || w_us);
  assign w_is_d = w_hi_ok && (w_lo >= 8'h30) && (w_lo <= 8'h39);
  assign w_at_max = (r_len == C_MAX_LEN);

  always_comb begin
    w_state_nx    = r_state;
    w_len_nx      = r_len;
    w_too_long_nx = r_too_long;
    w_tok         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_l) begin
          w_state_nx = S_ALPHA;
          w_len_nx   = C_ONE;
        end else if (w_is_d) begin
          w_state_nx    = S_ERR;
          w_too_long_nx = 1'b0;
        end
      end
      S_ALPHA: begin
        if (w_is_l || w_is_d) begin
          if (w_at_max) begin
            w_state_nx    = S_ERR;
            w_too_long_nx = 1'b1;
          end else begin
            w_state_nx = w_is_d ? S_DIGIT : S_ALPHA;
            w_len_nx   = r_len + C_ONE;
          end
        end else begin
          w_state_nx = S_IDLE;
          w_len_nx   = '0;
        end
      end
      S_DIGIT: begin
        if (w_is_d) begin
          if (w_at_max) begin
            w_state_nx    = S_ERR;
            w_too_long_nx = 1'b1;
          end else begin
            w_len_nx = r_len + C_ONE;
          end
        end else if (w_is_l) begin
          // A letter both closes the token and opens the next run.
          w_tok      = 1'b1;
          w_state_nx = S_ALPHA;
          w_len_nx   = C_ONE;
        end else begin
          w_tok      = 1'b1;
          w_state_nx = S_IDLE;
          w_len_nx   = '0;
        end
      end
      default: begin
        if (!(w_is_l || w_is_d)) begin
          w_state_nx    = S_IDLE;
          w_len_nx      = '0;
          w_too_long_nx = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_too_long  <= 1'b0;
      r_tok_valid <= 1'b0;
      r_tok_len   <= '0;
      r_tok_cnt   <= '0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_too_long  <= 1'b0;
      r_tok_valid <= 1'b0;
    end else if (in_valid) begin
      r_state     <= w_state_nx;
      r_len       <= w_len_nx;
      r_too_long  <= w_too_long_nx;
      r_tok_valid <= w_tok;
      if (w_tok) begin
        r_tok_len <= r_len;
        r_tok_cnt <= r_tok_cnt + 1'b1;
      end
    end else begin
      r_tok_valid <= 1'b0;
    end
  end

  assign match     = (r_state == S_DIGIT);
  assign cur_len   = r_len;
  assign too_long  = r_too_long;
  assign tok_valid = r_tok_valid;
  assign tok_len   = r_tok_len;
  assign tok_cnt   = r_tok_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_lexer.sv
// ============================================================================
//  Module  : tb_id_lexer
//  Brief   : Directed self-checking bench for id_lexer (MAX_LEN=16 and 4).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_lexer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] ch = 8'h00;

  logic       a_match, a_too_long, a_tok_valid;
  logic [4:0] a_len, a_tok_len;
  logic [7:0] a_cnt;
  logic       b_match, b_too_long, b_tok_valid;
  logic [2:0] b_len, b_tok_len;
  logic [7:0] b_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  id_lexer #(.CHAR_W(8), .MAX_LEN(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(ch), .clear(clear),
    .match(a_match), .cur_len(a_len), .too_long(a_too_long),
    .tok_valid(a_tok_valid), .tok_len(a_tok_len), .tok_cnt(a_cnt)
  );

  id_lexer #(.CHAR_W(8), .MAX_LEN(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(ch), .clear(clear),
    .match(b_match), .cur_len(b_len), .too_long(b_too_long),
    .tok_valid(b_tok_valid), .tok_len(b_tok_len), .tok_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] c, input logic v, input logic clr);
    @(negedge clk);
    ch = c;
    in_valid = v;
    clear = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic put(input logic [7:0] c);
    step(c, 1'b1, 1'b0);
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  initial begin
    string s1;
    s1 = "abcd1234/";
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match", 32'(a_match), 0);
    chk("rst_len", 32'(a_len), 0);
    chk("rst_toolong", 32'(a_too_long), 0);
    chk("rst_tokv", 32'(a_tok_valid), 0);
    chk("rst_toklen", 32'(a_tok_len), 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // abcd1234/ ; the MAX_LEN=4 instance overflows on '1'
    for (int i = 0; i < 8; i++) begin
      put(s1[i]);
      chk("t1_len", 32'(a_len), i + 1);
      chk("t1_match", 32'(a_match), (i >= 4) ? 1 : 0);
      if (i == 4) begin
        chk("t1_b_toolong", 32'(b_too_long), 1);
        chk("t1_b_len", 32'(b_len), 4);
        chk("t1_b_match", 32'(b_match), 0);
      end
    end
    put("/");
    exp_cnt++;
    chk("t1_tokv", 32'(a_tok_valid), 1);
    chk("t1_toklen", 32'(a_tok_len), 8);
    chk("t1_cnt", 32'(a_cnt), exp_cnt);
    chk("t1_match_end", 32'(a_match), 0);
    chk("t1_len_end", 32'(a_len), 0);
    chk("t1_b_tokv", 32'(b_tok_valid), 0);
    chk("t1_b_toolong_end", 32'(b_too_long), 0);
    step(8'h00, 1'b0, 1'b0);
    chk("idle_tokv", 32'(a_tok_valid), 0);
    chk("idle_toklen", 32'(a_tok_len), 8);
    chk("idle_cnt", 32'(a_cnt), exp_cnt);

    // ab12cd3/
    put_str("ab12");
    chk("t2_match", 32'(a_match), 1);
    put("c");
    exp_cnt++;
    chk("t2_tokv_c", 32'(a_tok_valid), 1);
    chk("t2_toklen_c", 32'(a_tok_len), 4);
    chk("t2_len_c", 32'(a_len), 1);
    chk("t2_match_c", 32'(a_match), 0);
    chk("t2_b_toklen_c", 32'(b_tok_len), 4);
    put("d");
    chk("t2_tokv_d", 32'(a_tok_valid), 0);
    put_str("3/");
    exp_cnt++;
    chk("t2_tokv_end", 32'(a_tok_valid), 1);
    chk("t2_toklen_end", 32'(a_tok_len), 3);
    chk("t2_cnt", 32'(a_cnt), exp_cnt);
    chk("t2_b_cnt", 32'(b_cnt), 2);

    // 9ab/ : digit-first run
    put("9");
    chk("t3_toolong", 32'(a_too_long), 0);
    chk("t3_match", 32'(a_match), 0);
    put_str("ab");
    chk("t3_match_b", 32'(a_match), 0);
    chk("t3_tokv_b", 32'(a_tok_valid), 0);
    put("/");
    chk("t3_tokv_end", 32'(a_tok_valid), 0);
    chk("t3_cnt", 32'(a_cnt), exp_cnt);
    put("a");
    chk("t3_idle_then_a", 32'(a_len), 1);
    put("/");

    // abc12/ on MAX_LEN=4
    put_str("abc1");
    chk("t4_b_len4", 32'(b_len), 4);
    chk("t4_b_match4", 32'(b_match), 1);
    put("2");
    chk("t4_b_toolong", 32'(b_too_long), 1);
    chk("t4_b_len_err", 32'(b_len), 4);
    put("/");
    exp_cnt++;
    chk("t4_b_tokv", 32'(b_tok_valid), 0);
    chk("t4_b_toolong_end", 32'(b_too_long), 0);
    chk("t4_b_cnt", 32'(b_cnt), 2);
    chk("t4_a_toklen", 32'(a_tok_len), 5);

    // ab1 then clear with in_valid high
    put_str("ab1");
    step("/", 1'b1, 1'b1);
    chk("t5_tokv", 32'(a_tok_valid), 0);
    chk("t5_match", 32'(a_match), 0);
    chk("t5_len", 32'(a_len), 0);
    chk("t5_cnt", 32'(a_cnt), exp_cnt);

    // in_valid low holds the run
    put("a");
    repeat (3) step("5", 1'b0, 1'b0);
    chk("hold_len", 32'(a_len), 1);
    chk("hold_match", 32'(a_match), 0);
    put("1");
    chk("hold_len2", 32'(a_len), 2);
    put("/");
    exp_cnt++;
    chk("hold_toklen", 32'(a_tok_len), 2);

    // a_1/
    put_str("a_1/");
`ifdef LEXER_UNDERSCORE_EN
    exp_cnt++;
    chk("t6_tokv", 32'(a_tok_valid), 1);
    chk("t6_toklen", 32'(a_tok_len), 3);
`else
    chk("t6_tokv", 32'(a_tok_valid), 0);
`endif
    chk("t6_cnt", 32'(a_cnt), exp_cnt);

    // 16 letters fit, the 17th overflows
    for (int i = 0; i < 16; i++) put("q");
    chk("ovf_len16", 32'(a_len), 16);
    chk("ovf_ok16", 32'(a_too_long), 0);
    put("q");
    chk("ovf_toolong", 32'(a_too_long), 1);
    chk("ovf_len", 32'(a_len), 16);
    put("/");
    chk("ovf_tokv", 32'(a_tok_valid), 0);
    chk("ovf_cnt", 32'(a_cnt), exp_cnt);

    // exactly MAX_LEN token
    for (int i = 0; i < 15; i++) put("K");
    put("7");
    chk("max_match", 32'(a_match), 1);
    put(" ");
    exp_cnt++;
    chk("max_tokv", 32'(a_tok_valid), 1);
    chk("max_toklen", 32'(a_tok_len), 16);
    chk("max_cnt", 32'(a_cnt), exp_cnt);

    // async reset mid-run
    put_str("Zz9");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_match", 32'(a_match), 0);
    chk("arst_len", 32'(a_len), 0);
    chk("arst_cnt", 32'(a_cnt), 0);
    chk("arst_toklen", 32'(a_tok_len), 0);
    @(negedge clk);
    rst_n = 1'b1;
    put("/");
    chk("arst_tokv", 32'(a_tok_valid), 0);

    // counter wrap
    for (int i = 0; i < 255; i++) put_str("a1/");
    chk("wrap_255", 32'(a_cnt), 255);
    put_str("b2/");
    chk("wrap_tokv", 32'(a_tok_valid), 1);
    chk("wrap_0", 32'(a_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
